// File: rtl/rvv_pkg.sv
// rvv_pkg: shared vector types for the SIMD sequencer and its lane.
//   vew_e : selected element width (SEW)
//   op_e  : lane operation
package rvv_pkg;

  typedef enum logic [1:0] {
    EW_8  = 2'd0,
    EW_16 = 2'd1,
    EW_32 = 2'd2,
    EW_64 = 2'd3
  } vew_e;

  typedef enum logic [2:0] {
    VADD  = 3'd0,
    VSUB  = 3'd1,
    VAND  = 3'd2,
    VADC  = 3'd3,
    VMACC = 3'd4
  } op_e;

endpackage

// File: rtl/spatz_simd_sequencer.sv
// spatz_simd_sequencer: accepts a vector request (op, SEW, signedness, vl),
// streams vl operand beats through an external combinational SIMD lane and
// returns the lane results on a registered, back-pressured result stream.
// Optional build macro SPATZ_SIMD_SEQ_PERF_EN adds a saturating stall counter
// on stall_cnt_o; without it stall_cnt_o is tied to zero.
//
// state | meaning
// IDLE  | waiting for a request; req_ready_o high
// BUSY  | issuing operand beats to the lane, one per fire
// DRAIN | all operands issued, waiting for the last result to be popped
module spatz_simd_sequencer
  import rvv_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned MaxVl = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  op_e                      req_op_i,
  input  vew_e                     req_sew_i,
  input  logic                     req_signed_i,
  input  logic [$clog2(MaxVl):0]   req_vl_i,
  input  logic                     opd_valid_i,
  output logic                     opd_ready_o,
  input  logic [Width-1:0]         opd_s1_i,
  input  logic [Width-1:0]         opd_s2_i,
  input  logic [Width-1:0]         opd_d_i,
  input  logic                     opd_carry_i,
  output op_e                      lane_op_o,
  output vew_e                     lane_sew_o,
  output logic                     lane_signed_o,
  output logic [Width-1:0]         lane_s1_o,
  output logic [Width-1:0]         lane_s2_o,
  output logic [Width-1:0]         lane_d_o,
  output logic                     lane_carry_o,
  input  logic [Width-1:0]         lane_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [Width-1:0]         res_data_o,
  output logic                     res_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              stall_cnt_o
);

  localparam int unsigned VlW = $clog2(MaxVl) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  op_e              op_q, op_d;
  vew_e             sew_q, sew_d;
  logic             signed_q, signed_d;
  logic [VlW-1:0]   vl_q, vl_d;
  logic [VlW-1:0]   cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_last_q, res_last_d;
  logic [Width-1:0] res_data_q, res_data_d;
  logic             done_q, done_d;

  logic [VlW-1:0]   req_vl_clamped;
  logic             req_fire, opd_fire, res_pop, cnt_last;

  assign req_vl_clamped = (req_vl_i > VlW'(MaxVl)) ? VlW'(MaxVl) : req_vl_i;
  assign req_ready_o    = (state_q == IDLE);
  assign req_fire       = req_valid_i && req_ready_o;
  // The result register can take a new element if it is empty or being popped.
  assign opd_ready_o    = (state_q == BUSY) && (!res_valid_q || res_ready_i);
  assign opd_fire       = opd_valid_i && opd_ready_o;
  assign res_pop        = res_valid_q && res_ready_i;
  assign cnt_last       = (cnt_q == vl_q - VlW'(1));

  assign lane_op_o      = op_q;
  assign lane_sew_o     = sew_q;
  assign lane_signed_o  = signed_q;
  assign lane_s1_o      = opd_s1_i;
  assign lane_s2_o      = opd_s2_i;
  assign lane_d_o       = opd_d_i;
  assign lane_carry_o   = opd_carry_i;

  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_last_o     = res_last_q;
  assign busy_o         = (state_q == BUSY) || (state_q == DRAIN);
  assign done_o         = done_q;

  // Next-state logic for the FSM, request latches and element counter.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sew_d    = sew_q;
    signed_d = signed_q;
    vl_d     = vl_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_vl_clamped != '0) begin
            op_d     = req_op_i;
            sew_d    = req_sew_i;
            signed_d = req_signed_i;
            vl_d     = req_vl_clamped;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            // Empty request completes immediately without touching the lane.
            done_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (opd_fire) begin
          cnt_d = cnt_q + VlW'(1);
          if (cnt_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result register: load on operand fire, otherwise clear on pop, else hold.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    if (opd_fire) begin
      res_valid_d = 1'b1;
      res_data_d  = lane_result_i;
      res_last_d  = cnt_last;
    end else if (res_pop) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset discarding any in-flight request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= VADD;
      sew_q       <= EW_8;
      signed_q    <= 1'b0;
      vl_q        <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sew_q       <= sew_d;
      signed_q    <= signed_d;
      vl_q        <= vl_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
    end
  end

`ifdef SPATZ_SIMD_SEQ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: BUSY cycles starved of operands or blocked on the result.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_fire) begin
      stall_cnt_d = '0;
    end else if ((state_q == BUSY) && (!opd_valid_i || (res_valid_q && !res_ready_i))
                 && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spatz_simd_sequencer.sv
// tb_spatz_simd_sequencer: table of requests plus hand-written corner-case
// sequences; a reference lane model produces the lane result and a
// scoreboard queue holds the expected result stream.
module tb_spatz_simd_sequencer;
  import rvv_pkg::*;

  localparam int W     = 32;
  localparam int MAXVL = 16;
  localparam int VLW   = $clog2(MAXVL) + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } sb_t;

  typedef struct {
    op_e         op;
    int          vl;
    int          exp_vl;
    logic [15:0] mask;
    int          exp_cycles;
  } vec_t;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_valid_i, req_ready_o;
  op_e            req_op_i;
  vew_e           req_sew_i;
  logic           req_signed_i;
  logic [VLW-1:0] req_vl_i;
  logic           opd_valid_i, opd_ready_o;
  logic [W-1:0]   opd_s1_i, opd_s2_i, opd_d_i;
  logic           opd_carry_i;
  op_e            lane_op_o;
  vew_e           lane_sew_o;
  logic           lane_signed_o;
  logic [W-1:0]   lane_s1_o, lane_s2_o, lane_d_o;
  logic           lane_carry_o;
  logic [W-1:0]   lane_result_i;
  logic           res_valid_o, res_ready_i;
  logic [W-1:0]   res_data_o;
  logic           res_last_o;
  logic           busy_o, done_o;
  logic [31:0]    stall_cnt_o;

  spatz_simd_sequencer #(.Width(W), .MaxVl(MAXVL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_sew_i(req_sew_i), .req_signed_i(req_signed_i), .req_vl_i(req_vl_i),
    .opd_valid_i(opd_valid_i), .opd_ready_o(opd_ready_o),
    .opd_s1_i(opd_s1_i), .opd_s2_i(opd_s2_i), .opd_d_i(opd_d_i), .opd_carry_i(opd_carry_i),
    .lane_op_o(lane_op_o), .lane_sew_o(lane_sew_o), .lane_signed_o(lane_signed_o),
    .lane_s1_o(lane_s1_o), .lane_s2_o(lane_s2_o), .lane_d_o(lane_d_o), .lane_carry_o(lane_carry_o),
    .lane_result_i(lane_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_last_o(res_last_o),
    .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] lane_fn(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] d, input logic c);
    case (op)
      VADD:    lane_fn = a + b;
      VSUB:    lane_fn = a - b;
      VAND:    lane_fn = a & b;
      VADC:    lane_fn = a + b + {{(W-1){1'b0}}, c};
      VMACC:   lane_fn = a * b + d;
      default: lane_fn = '0;
    endcase
  endfunction

  // Combinational SIMD lane seen by the DUT.
  always_comb lane_result_i = lane_fn(lane_op_o, lane_s1_o, lane_s2_o, lane_d_o, lane_carry_o);

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  int   pops, done_cnt, elem_idx, cur_vl;
  bit   accepted, busy_seen, acc_done;
  op_e  cur_op;
  vew_e cur_sew;
  logic cur_signed;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_opd();
    opd_s1_i    = $urandom;
    opd_s2_i    = $urandom;
    opd_d_i     = $urandom;
    opd_carry_i = 1'($urandom_range(0, 1));
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic cycle();
    sb_t e;
    @(negedge clk_i);
    check("req_ready_vs_busy", req_ready_o, !busy_o);
    if (busy_o) begin
      busy_seen = 1'b1;
      check("lane_attr", {lane_op_o, lane_sew_o, lane_signed_o}, {cur_op, cur_sew, cur_signed});
    end
    if (opd_valid_i && opd_ready_o) begin
      e.data = lane_fn(cur_op, opd_s1_i, opd_s2_i, opd_d_i, opd_carry_i);
      e.last = (elem_idx == cur_vl - 1);
      sb_q.push_back(e);
      elem_idx++;
    end
    if (res_valid_o && res_ready_i) begin
      if (sb_q.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("res_data", res_data_o, e.data);
        check("res_last", res_last_o, e.last);
        pops++;
      end
    end
    if (done_o) done_cnt++;
    if (req_valid_i && req_ready_o) begin
      accepted   = 1'b1;
      acc_done   = done_o;
      cur_op     = req_op_i;
      cur_sew    = req_sew_i;
      cur_signed = req_signed_i;
      cur_vl     = (int'(req_vl_i) > MAXVL) ? MAXVL : int'(req_vl_i);
      elem_idx   = 0;
      pops       = 0;
      done_cnt   = 0;
      busy_seen  = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_req(input op_e op, input int vl);
    int n;
    n            = 0;
    accepted     = 1'b0;
    opd_valid_i  = 1'b0;
    req_valid_i  = 1'b1;
    req_op_i     = op;
    req_sew_i    = vew_e'($urandom_range(0, 3));
    req_signed_i = 1'($urandom_range(0, 1));
    req_vl_i     = VLW'(vl);
    while (!accepted && n < 10) begin
      cycle();
      n++;
    end
    check("accept", accepted, 1);
    // Scramble request fields so an unlatched attribute shows up on the lane.
    req_valid_i  = 1'b0;
    req_op_i     = (op == VAND) ? VADD : VAND;
    req_sew_i    = vew_e'(~cur_sew);
    req_signed_i = ~cur_signed;
    req_vl_i     = '0;
  endtask

  task automatic finish_req(input int exp_vl, input logic [15:0] mask, input int exp_cycles);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      opd_valid_i = 1'b1;
      drive_opd();
      res_ready_i = mask[n % 16];
      n++;
      cycle();
    end
    check("done_seen", done_cnt, 1);
    if (exp_cycles != 0) check("latency", n, exp_cycles);
    check("pop_count", pops, exp_vl);
    check("sb_empty", sb_q.size(), 0);
    check("busy_seen", busy_seen, (exp_vl > 0));
    opd_valid_i = 1'b0;
    res_ready_i = 1'b1;
    cycle();
    check("done_width", done_cnt, 1);
    check("idle_after", {req_ready_o, busy_o, res_valid_o}, 3'b100);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   n;
    bit   got;
    logic [W-1:0] held;
    int   exp_stall;

    vecs[0] = '{VADD,  4,  4,  16'hFFFF, 6};
    vecs[1] = '{VSUB,  1,  1,  16'hFFFF, 3};
    vecs[2] = '{VMACC, 5,  5,  16'h5555, 0};
    vecs[3] = '{VADC,  3,  3,  16'hFFFF, 5};
    vecs[4] = '{VAND,  20, 16, 16'hFFFF, 18};
    vecs[5] = '{VADD,  0,  0,  16'hFFFF, 1};
    vecs[6] = '{VSUB,  16, 16, 16'h3333, 0};

    req_valid_i = 1'b0; req_op_i = VADD; req_sew_i = EW_8; req_signed_i = 1'b0; req_vl_i = '0;
    opd_valid_i = 1'b0; opd_s1_i = '0; opd_s2_i = '0; opd_d_i = '0; opd_carry_i = 1'b0;
    res_ready_i = 1'b1;
    pops = 0; done_cnt = 0; elem_idx = 0; cur_vl = 0;
    accepted = 1'b0; busy_seen = 1'b0; acc_done = 1'b0;
    cur_op = VADD; cur_sew = EW_8; cur_signed = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_outputs", {req_ready_o, busy_o, res_valid_o, res_last_o, done_o, opd_ready_o}, 6'b100000);
    check("rst_data", res_data_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 7; i++) begin
      issue_req(vecs[i].op, vecs[i].vl);
      finish_req(vecs[i].exp_vl, vecs[i].mask, vecs[i].exp_cycles);
    end

    // Result back-pressure: hold res_ready_i low for 5 cycles after the first result.
    issue_req(VSUB, 3);
    opd_valid_i = 1'b1;
    drive_opd();
    res_ready_i = 1'b0;
    cycle();
    check("hold_first_valid", res_valid_o, 1);
    held = res_data_o;
    for (int k = 0; k < 5; k++) begin
      drive_opd();
      check("hold_opd_ready", opd_ready_o, 0);
      check("hold_data", res_data_o, held);
      check("hold_valid", res_valid_o, 1);
      cycle();
    end
    finish_req(3, 16'hFFFF, 0);

    // Asynchronous reset in the middle of an 8-element request.
    issue_req(VADD, 8);
    n = 0;
    while (elem_idx < 2 && n < 20) begin
      opd_valid_i = 1'b1;
      drive_opd();
      res_ready_i = 1'b1;
      cycle();
      n++;
    end
    check("mid_reached", elem_idx, 2);
    opd_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("arst_outputs", {req_ready_o, busy_o, res_valid_o, res_last_o, done_o, opd_ready_o}, 6'b100000);
    check("arst_data", res_data_o, 0);
    check("arst_stall", stall_cnt_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb_q.delete();
    elem_idx = 0;
    @(posedge clk_i);
    #1;
    issue_req(VADD, 2);
    finish_req(2, 16'hFFFF, 4);

    // Back-to-back: second request presented while done_o is high.
    issue_req(VAND, 2);
    accepted = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      opd_valid_i = 1'b1;
      drive_opd();
      res_ready_i = 1'b1;
      if (done_o) begin
        check("b2b_first_pops", pops, 2);
        req_valid_i  = 1'b1;
        req_op_i     = VADC;
        req_sew_i    = EW_16;
        req_signed_i = 1'b1;
        req_vl_i     = VLW'(3);
        opd_valid_i  = 1'b0;
        got = 1'b1;
      end
      n++;
      cycle();
    end
    check("b2b_accepted", accepted, 1);
    check("b2b_acc_with_done", acc_done, 1);
    req_valid_i = 1'b0;
    req_op_i    = VAND;
    req_vl_i    = '0;
    finish_req(3, 16'hFFFF, 5);

    // Operand starvation for 3 BUSY cycles.
`ifdef SPATZ_SIMD_SEQ_PERF_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    issue_req(VADD, 2);
    opd_valid_i = 1'b0;
    res_ready_i = 1'b1;
    repeat (3) cycle();
    finish_req(2, 16'hFFFF, 0);
    check("stall_at_done", stall_cnt_o, exp_stall);
    issue_req(VSUB, 1);
    finish_req(1, 16'hFFFF, 3);
    check("stall_cleared", stall_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
